ysyx_210544_cache_split: RTL and testbench
==========================================

// Module: ysyx_210544_cache_split
// PURPOSE
//  Parametrised unaligned-access splitter between the LSU/IFU and a cache_basic-style port.
//  Accepts one request through a valid/ready handshake and latches it.
//  Issues 1 or 2 line-contained downstream accesses, then returns one merged response pulse.
//  Beyond the fixed 16-byte splitter it adds: configurable line size, request latching,
//  error propagation, and a trap-instead-of-split mode.
// PARAMETERS
//  AW            64  address width
//  LINE_BYTES    16  cache line bytes; power of 2, >= 8; OFF_W = log2(LINE_BYTES)
//  SPLIT_EN      1   1: split line-crossing accesses; 0: reject them with o_resp_err, no downstream access
// PORTS
//  clk           in   1    clock
//  rst           in   1    asynchronous active-high reset
//  i_req_valid   in   1    upstream request valid
//  o_req_ready   out  1    1 only in IDLE
//  i_req_addr    in   AW   byte address, any alignment
//  i_req_op      in   1    0 read, 1 write
//  i_req_bytes   in   3    byte count minus 1 (0..7)
//  i_req_wdata   in   64   write data, LSB-aligned
//  o_resp_valid  out  1    one-cycle completion pulse
//  o_resp_rdata  out  64   merged read data, LSB-aligned, zero above the accessed bytes
//  o_resp_err    out  1    valid with o_resp_valid
//  o_cb_req      out  1    downstream request; held until i_cb_ack
//  o_cb_addr     out  AW   downstream address
//  o_cb_op       out  1    downstream op
//  o_cb_bytes    out  3    downstream byte count minus 1
//  o_cb_wdata    out  64   downstream write data
//  i_cb_rdata    in   64   downstream read data, valid with i_cb_ack
//  i_cb_ack      in   1    downstream completion
//  i_cb_err      in   1    downstream error, valid with i_cb_ack
// BEHAVIOUR
//  Reset (async) values: all outputs 0 except o_req_ready=1; state IDLE; latched fields 0.
//  States: IDLE, REQ0, GAP, REQ1, RESP.
//  Accept: i_req_valid & o_req_ready at edge T latches addr/op/bytes/wdata.
//    Later input changes are ignored.
//  Crossing arithmetic (latched values):
//    off = addr[OFF_W-1:0]; end = off + bytes (OFF_W+1 bits); cross = end >= LINE_BYTES.
//  Split fields:
//    bytes0 = cross ? LINE_BYTES-1-off : bytes
//    bytes1 = end - LINE_BYTES (low 3 bits)
//    addr0 = addr; addr1 = {addr[AW-1:OFF_W]+1, OFF_W'b0}, wraps mod 2^AW
//    wdata1 = wdata >> 8*(bytes0+1)
//  Non-crossing: IDLE -> REQ0. o_cb_req=1 from T+1, fields = addr0/bytes0/wdata.
//    Ack at cycle A: REQ0 -> RESP. o_resp_valid=1 at A+1, then IDLE (ready=1 at A+2).
//  Crossing & SPLIT_EN=1: REQ0 ack -> GAP. o_cb_req=0 for exactly one cycle,
//    rdata0 masked to bytes0+1 bytes and stored.
//    GAP -> REQ1: o_cb_req=1 with addr1/bytes1/wdata1. Ack -> RESP.
//    rdata = rdata0 | (i_cb_rdata << 8*(bytes0+1)).
//  Crossing & SPLIT_EN=0: IDLE -> RESP directly. No o_cb_req.
//    o_resp_err=1, rdata=0, pulse at T+1.
//  i_cb_err on piece 0: piece 1 is skipped, go to RESP with err=1, rdata=0.
//    On piece 1: err=1, rdata=0 (write of piece 0 is NOT rolled back).
//  o_cb_req drops the cycle after ack; o_cb_* fields stay stable while o_cb_req=1.
//  i_cb_ack while o_cb_req=0 is ignored.
//  o_resp_rdata/o_resp_err hold until the next response; o_resp_valid is high for one cycle only.
//  Read returns the full 64-bit merged value; sign extension is the consumer's job.
//  Reset mid-operation: o_cb_req and o_resp_valid drop immediately (async), state IDLE;
//    in-flight downstream transaction is abandoned.
// TESTING
//  1. Read addr=0x1003 bytes=3, ack 2 cycles later, rdata=0x44332211 -> one cb access (0x1003,3); resp rdata=0x44332211, err=0.
//  2. Read addr=0x100D bytes=7, LINE=16 -> cb (0x100D,2) then one idle cycle, then (0x1010,4); rdata0=0xCCBBAA, rdata1=0x5544332211 -> resp 0x5544332211CCBBAA.
//  3. Write addr=0x103E bytes=3 wdata=0xDDCCBBAA, LINE=64 -> (0x103E,1,0xDDCCBBAA) then (0x1040,1,0xDDCC).
//  4. SPLIT_EN=0, read addr=0x0F bytes=1 -> no o_cb_req; resp_valid at T+1 with err=1, rdata=0.
//  5. Crossing read, i_cb_err=1 on piece 0 -> no second o_cb_req; resp err=1, rdata=0. Address 0xFFFF_FFFF_FFFF_FFFE bytes=3 -> addr1=0.
//  6. Assert rst while o_cb_req=1 in REQ1 -> o_cb_req=0 same cycle, o_req_ready=1; next request processes normally.

Source files
------------

// File: rtl/ysyx_210544_cache_split.sv
// Unaligned-access splitter: turns one LSU/IFU request into one or two line-contained
// downstream accesses and returns a single merged response.
module ysyx_210544_cache_split #(
    parameter int AW         = 64,
    parameter int LINE_BYTES = 16,
    parameter bit SPLIT_EN   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [AW-1:0] i_req_addr,
    input  logic          i_req_op,
    input  logic [2:0]    i_req_bytes,
    input  logic [63:0]   i_req_wdata,
    output logic          o_resp_valid,
    output logic [63:0]   o_resp_rdata,
    output logic          o_resp_err,
    output logic          o_cb_req,
    output logic [AW-1:0] o_cb_addr,
    output logic          o_cb_op,
    output logic [2:0]    o_cb_bytes,
    output logic [63:0]   o_cb_wdata,
    input  logic [63:0]   i_cb_rdata,
    input  logic          i_cb_ack,
    input  logic          i_cb_err
);

    localparam int OFF_W = $clog2(LINE_BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ0 = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_REQ1 = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    // Keep only the low n+1 bytes of d (n is byte count minus 1).
    function automatic logic [63:0] f_mask(input logic [63:0] d, input logic [2:0] n);
        logic [6:0] sh;
        sh     = {({1'b0, n} + 4'd1), 3'b000};
        f_mask = d & ~(64'hFFFF_FFFF_FFFF_FFFF << sh);
    endfunction

    // Byte shift amount for n+1 bytes.
    function automatic logic [6:0] f_shamt(input logic [2:0] n);
        f_shamt = {({1'b0, n} + 4'd1), 3'b000};
    endfunction

    logic [2:0]    r_state;
    logic [AW-1:0] r_addr;
    logic          r_op;
    logic [2:0]    r_bytes;
    logic [63:0]   r_wdata;
    logic [63:0]   r_rdata0;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic [63:0]   r_resp_rdata;
    logic          r_resp_err;
    logic          r_cb_req;
    logic [AW-1:0] r_cb_addr;
    logic          r_cb_op;
    logic [2:0]    r_cb_bytes;
    logic [63:0]   r_cb_wdata;

    // Crossing arithmetic on the incoming request (used at accept time).
    logic [OFF_W-1:0] w_in_off;
    logic [OFF_W:0]   w_in_end;
    logic             w_in_cross;
    logic [2:0]       w_in_bytes0;

    // Crossing arithmetic on the latched request.
    logic [OFF_W-1:0] w_off;
    logic [OFF_W:0]   w_end;
    logic             w_cross;
    logic [2:0]       w_bytes0;
    logic [2:0]       w_bytes1;
    logic [AW-1:0]    w_addr1;
    logic [63:0]      w_wdata1;

    assign w_in_off    = i_req_addr[OFF_W-1:0];
    assign w_in_end    = {1'b0, w_in_off} + {{(OFF_W-2){1'b0}}, i_req_bytes};
    assign w_in_cross  = (w_in_end >= (OFF_W+1)'(LINE_BYTES));
    // LINE_BYTES-1-off is ~off; it is at most 6 whenever the access crosses.
    assign w_in_bytes0 = w_in_cross ? ~w_in_off[2:0] : i_req_bytes;

    assign w_off    = r_addr[OFF_W-1:0];
    assign w_end    = {1'b0, w_off} + {{(OFF_W-2){1'b0}}, r_bytes};
    assign w_cross  = (w_end >= (OFF_W+1)'(LINE_BYTES));
    assign w_bytes0 = w_cross ? ~w_off[2:0] : r_bytes;
    assign w_bytes1 = w_end[2:0];
    assign w_addr1  = {r_addr[AW-1:OFF_W] + (AW-OFF_W)'(1), {OFF_W{1'b0}}};
    assign w_wdata1 = r_wdata >> f_shamt(w_bytes0);

    // Request sequencing FSM with registered handshake and downstream fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_op         <= 1'b0;
            r_bytes      <= 3'd0;
            r_wdata      <= 64'd0;
            r_rdata0     <= 64'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
            r_cb_req     <= 1'b0;
            r_cb_addr    <= '0;
            r_cb_op      <= 1'b0;
            r_cb_bytes   <= 3'd0;
            r_cb_wdata   <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_addr      <= i_req_addr;
                        r_op        <= i_req_op;
                        r_bytes     <= i_req_bytes;
                        r_wdata     <= i_req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_in_cross && !SPLIT_EN) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 64'd0;
                        end else begin
                            r_state    <= S_REQ0;
                            r_cb_req   <= 1'b1;
                            r_cb_addr  <= i_req_addr;
                            r_cb_op    <= i_req_op;
                            r_cb_bytes <= w_in_bytes0;
                            r_cb_wdata <= i_req_wdata;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ0: begin
                    if (i_cb_ack) begin
                        r_cb_req <= 1'b0;
                        if (i_cb_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 64'd0;
                        end else if (w_cross) begin
                            r_state  <= S_GAP;
                            r_rdata0 <= f_mask(i_cb_rdata, w_bytes0);
                        end else begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= f_mask(i_cb_rdata, r_bytes);
                        end
                    end else begin
                        r_state <= S_REQ0;
                    end
                end
                S_GAP: begin
                    r_state    <= S_REQ1;
                    r_cb_req   <= 1'b1;
                    r_cb_addr  <= w_addr1;
                    r_cb_op    <= r_op;
                    r_cb_bytes <= w_bytes1;
                    r_cb_wdata <= w_wdata1;
                end
                S_REQ1: begin
                    if (i_cb_ack) begin
                        r_cb_req     <= 1'b0;
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        if (i_cb_err) begin
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 64'd0;
                        end else begin
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= f_mask(r_rdata0 | (i_cb_rdata << f_shamt(w_bytes0)), r_bytes);
                        end
                    end else begin
                        r_state <= S_REQ1;
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_cb_req     <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
    assign o_cb_req     = r_cb_req;
    assign o_cb_addr    = r_cb_addr;
    assign o_cb_op      = r_cb_op;
    assign o_cb_bytes   = r_cb_bytes;
    assign o_cb_wdata   = r_cb_wdata;

endmodule

// File: tb/tb_ysyx_210544_cache_split.sv
// Directed bench for the unaligned-access splitter: three instances cover
// 16-byte lines, 64-byte lines and the trap-instead-of-split mode.
module tb_ysyx_210544_cache_split;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req_addr;
    logic        req_op;
    logic [2:0]  req_bytes;
    logic [63:0] req_wdata;
    logic [63:0] cb_rdata;
    logic        cb_err;

    logic va, vb, vc, acka, ackb, ackc;
    logic        ready_a, rv_a, err_a, cbq_a, cbop_a;
    logic [63:0] rd_a, cba_a, cbw_a;
    logic [2:0]  cbb_a;
    logic        ready_b, rv_b, err_b, cbq_b, cbop_b;
    logic [63:0] rd_b, cba_b, cbw_b;
    logic [2:0]  cbb_b;
    logic        ready_c, rv_c, err_c, cbq_c, cbop_c;
    logic [63:0] rd_c, cba_c, cbw_c;
    logic [2:0]  cbb_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_210544_cache_split #(.AW(64), .LINE_BYTES(16), .SPLIT_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .i_req_valid(va), .o_req_ready(ready_a),
        .i_req_addr(req_addr), .i_req_op(req_op), .i_req_bytes(req_bytes), .i_req_wdata(req_wdata),
        .o_resp_valid(rv_a), .o_resp_rdata(rd_a), .o_resp_err(err_a),
        .o_cb_req(cbq_a), .o_cb_addr(cba_a), .o_cb_op(cbop_a), .o_cb_bytes(cbb_a), .o_cb_wdata(cbw_a),
        .i_cb_rdata(cb_rdata), .i_cb_ack(acka), .i_cb_err(cb_err));

    ysyx_210544_cache_split #(.AW(64), .LINE_BYTES(64), .SPLIT_EN(1'b1)) u_b (
        .clk(clk), .rst(rst), .i_req_valid(vb), .o_req_ready(ready_b),
        .i_req_addr(req_addr), .i_req_op(req_op), .i_req_bytes(req_bytes), .i_req_wdata(req_wdata),
        .o_resp_valid(rv_b), .o_resp_rdata(rd_b), .o_resp_err(err_b),
        .o_cb_req(cbq_b), .o_cb_addr(cba_b), .o_cb_op(cbop_b), .o_cb_bytes(cbb_b), .o_cb_wdata(cbw_b),
        .i_cb_rdata(cb_rdata), .i_cb_ack(ackb), .i_cb_err(cb_err));

    ysyx_210544_cache_split #(.AW(64), .LINE_BYTES(16), .SPLIT_EN(1'b0)) u_c (
        .clk(clk), .rst(rst), .i_req_valid(vc), .o_req_ready(ready_c),
        .i_req_addr(req_addr), .i_req_op(req_op), .i_req_bytes(req_bytes), .i_req_wdata(req_wdata),
        .o_resp_valid(rv_c), .o_resp_rdata(rd_c), .o_resp_err(err_c),
        .o_cb_req(cbq_c), .o_cb_addr(cba_c), .o_cb_op(cbop_c), .o_cb_bytes(cbb_c), .o_cb_wdata(cbw_c),
        .i_cb_rdata(cb_rdata), .i_cb_ack(ackc), .i_cb_err(cb_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; va = 1'b0; vb = 1'b0; vc = 1'b0;
        acka = 1'b0; ackb = 1'b0; ackc = 1'b0;
        req_addr = 64'd0; req_op = 1'b0; req_bytes = 3'd0; req_wdata = 64'd0;
        cb_rdata = 64'd0; cb_err = 1'b0;
        tick(); tick();
        chk("rst_ready", {63'd0, ready_a}, 64'd1);
        chk("rst_cb_req", {63'd0, cbq_a}, 64'd0);
        chk("rst_resp_valid", {63'd0, rv_a}, 64'd0);
        chk("rst_rdata", rd_a, 64'd0);
        chk("rst_cb_addr", cba_a, 64'd0);
        rst = 1'b0;
        tick();

        // Stray ack while idle must do nothing.
        acka = 1'b1; tick(); acka = 1'b0;
        chk("stray_ack_rv", {63'd0, rv_a}, 64'd0);
        chk("stray_ack_ready", {63'd0, ready_a}, 64'd1);

        // 1: non-crossing read, ack two cycles after issue
        req_addr = 64'h1003; req_bytes = 3'd3; req_op = 1'b0; va = 1'b1;
        tick();
        va = 1'b0; req_addr = 64'hDEAD; req_bytes = 3'd7;
        chk("t1_cb_req", {63'd0, cbq_a}, 64'd1);
        chk("t1_cb_addr", cba_a, 64'h1003);
        chk("t1_cb_bytes", {61'd0, cbb_a}, 64'd3);
        chk("t1_ready_busy", {63'd0, ready_a}, 64'd0);
        tick();
        chk("t1_cb_addr_hold", cba_a, 64'h1003);
        acka = 1'b1; cb_rdata = 64'h44332211;
        tick();
        acka = 1'b0;
        chk("t1_rv", {63'd0, rv_a}, 64'd1);
        chk("t1_rdata", rd_a, 64'h44332211);
        chk("t1_err", {63'd0, err_a}, 64'd0);
        chk("t1_cb_drop", {63'd0, cbq_a}, 64'd0);
        tick();
        chk("t1_rv_pulse", {63'd0, rv_a}, 64'd0);
        chk("t1_ready_back", {63'd0, ready_a}, 64'd1);
        chk("t1_rdata_hold", rd_a, 64'h44332211);

        // 2: crossing read split into (0x100D,2) and (0x1010,4)
        req_addr = 64'h100D; req_bytes = 3'd7; va = 1'b1;
        tick();
        va = 1'b0;
        chk("t2_cb0_addr", cba_a, 64'h100D);
        chk("t2_cb0_bytes", {61'd0, cbb_a}, 64'd2);
        acka = 1'b1; cb_rdata = 64'hFFFF_FFFF_FFCC_BBAA;
        tick();
        acka = 1'b0;
        chk("t2_gap", {63'd0, cbq_a}, 64'd0);
        chk("t2_gap_rv", {63'd0, rv_a}, 64'd0);
        tick();
        chk("t2_cb1_req", {63'd0, cbq_a}, 64'd1);
        chk("t2_cb1_addr", cba_a, 64'h1010);
        chk("t2_cb1_bytes", {61'd0, cbb_a}, 64'd4);
        acka = 1'b1; cb_rdata = 64'h55_4433_2211;
        tick();
        acka = 1'b0;
        chk("t2_rv", {63'd0, rv_a}, 64'd1);
        chk("t2_rdata", rd_a, 64'h5544_3322_11CC_BBAA);
        chk("t2_err", {63'd0, err_a}, 64'd0);
        tick();

        // 3: 64-byte line crossing write
        req_addr = 64'h103E; req_bytes = 3'd3; req_op = 1'b1; req_wdata = 64'hDDCCBBAA; vb = 1'b1;
        tick();
        vb = 1'b0;
        chk("t3_cb0_addr", cba_b, 64'h103E);
        chk("t3_cb0_bytes", {61'd0, cbb_b}, 64'd1);
        chk("t3_cb0_wdata", cbw_b, 64'hDDCCBBAA);
        chk("t3_cb0_op", {63'd0, cbop_b}, 64'd1);
        ackb = 1'b1; cb_rdata = 64'd0;
        tick();
        ackb = 1'b0;
        tick();
        chk("t3_cb1_addr", cba_b, 64'h1040);
        chk("t3_cb1_bytes", {61'd0, cbb_b}, 64'd1);
        chk("t3_cb1_wdata", cbw_b, 64'hDDCC);
        ackb = 1'b1;
        tick();
        ackb = 1'b0;
        chk("t3_rv", {63'd0, rv_b}, 64'd1);
        chk("t3_err", {63'd0, err_b}, 64'd0);
        tick();

        // 4: trap mode rejects a crossing access without a downstream request
        req_addr = 64'h0F; req_bytes = 3'd1; req_op = 1'b0; vc = 1'b1;
        tick();
        vc = 1'b0;
        chk("t4_rv", {63'd0, rv_c}, 64'd1);
        chk("t4_err", {63'd0, err_c}, 64'd1);
        chk("t4_rdata", rd_c, 64'd0);
        chk("t4_no_cb", {63'd0, cbq_c}, 64'd0);
        tick();
        chk("t4_ready", {63'd0, ready_c}, 64'd1);
        chk("t4_no_cb2", {63'd0, cbq_c}, 64'd0);

        // 5a: error on piece 0 skips piece 1
        req_addr = 64'h100D; req_bytes = 3'd7; va = 1'b1;
        tick();
        va = 1'b0;
        acka = 1'b1; cb_err = 1'b1; cb_rdata = 64'h1234;
        tick();
        acka = 1'b0; cb_err = 1'b0;
        chk("t5_rv", {63'd0, rv_a}, 64'd1);
        chk("t5_err", {63'd0, err_a}, 64'd1);
        chk("t5_rdata", rd_a, 64'd0);
        tick();
        chk("t5_no_cb1", {63'd0, cbq_a}, 64'd0);
        chk("t5_ready", {63'd0, ready_a}, 64'd1);

        // 5b: address wraps to zero for piece 1
        req_addr = 64'hFFFF_FFFF_FFFF_FFFE; req_bytes = 3'd3; req_op = 1'b1; req_wdata = 64'h44332211; va = 1'b1;
        tick();
        va = 1'b0;
        chk("t5w_cb0_bytes", {61'd0, cbb_a}, 64'd1);
        acka = 1'b1;
        tick();
        acka = 1'b0;
        tick();
        chk("t5w_cb1_addr", cba_a, 64'd0);
        chk("t5w_cb1_bytes", {61'd0, cbb_a}, 64'd1);
        chk("t5w_cb1_wdata", cbw_a, 64'h4433);
        chk("t5w_cb1_op", {63'd0, cbop_a}, 64'd1);

        // 5c: error on piece 1 still reports err with zero data
        acka = 1'b1; cb_err = 1'b1;
        tick();
        acka = 1'b0; cb_err = 1'b0;
        chk("t5e_rv", {63'd0, rv_a}, 64'd1);
        chk("t5e_err", {63'd0, err_a}, 64'd1);
        chk("t5e_rdata", rd_a, 64'd0);
        tick();

        // 6: async reset while piece 1 is outstanding
        req_addr = 64'h100D; req_bytes = 3'd7; req_op = 1'b0; va = 1'b1;
        tick();
        va = 1'b0;
        acka = 1'b1; cb_rdata = 64'hAA;
        tick();
        acka = 1'b0;
        tick();
        chk("t6_in_req1", {63'd0, cbq_a}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_cb_drop", {63'd0, cbq_a}, 64'd0);
        chk("t6_ready", {63'd0, ready_a}, 64'd1);
        chk("t6_rv", {63'd0, rv_a}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        req_addr = 64'h2000; req_bytes = 3'd7; va = 1'b1;
        tick();
        va = 1'b0;
        chk("t6_next_addr", cba_a, 64'h2000);
        chk("t6_next_bytes", {61'd0, cbb_a}, 64'd7);
        acka = 1'b1; cb_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        acka = 1'b0;
        chk("t6_next_rv", {63'd0, rv_a}, 64'd1);
        chk("t6_next_rdata", rd_a, 64'h0123_4567_89AB_CDEF);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
